// File: rtl/spi_flash_responder_if.sv
// SPI pins plus the synchronous memory read port of the flash responder.
// slave is the responder's view and master is the initiator/memory view.
interface spi_flash_responder_if;
  logic        spi_clk;
  logic        csb;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic        mem_rd_o;
  logic [23:0] mem_addr_o;
  logic [7:0]  mem_rdata_i;

  modport slave (
    input  spi_clk, csb, mosi, mem_rdata_i,
    output miso, miso_oe, mem_rd_o, mem_addr_o
  );

  modport master (
    output spi_clk, csb, mosi, mem_rdata_i,
    input  miso, miso_oe, mem_rd_o, mem_addr_o
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash model: oversamples the bus and answers READ (0x03) from an
// external synchronous memory and JEDEC-ID (0x9F) from a constant.
module spi_flash_responder #(
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  spi_flash_responder_if.slave  bus
);

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_ID, S_IGNORE
  } state_e;

  logic sck_s1_q, sck_s2_q, sck_s3_q;
  logic csb_s1_q, csb_s2_q;
  logic mosi_s1_q, mosi_s2_q;
  logic vld1_q, vld2_q;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]   in_shift_q, in_shift_d;
  logic [DATA_W-1:0]   out_shift_q, out_shift_d;
  logic [DATA_W-1:0]   pf_q, pf_d;
  logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
  logic [IDX_W-1:0]    id_idx_q, id_idx_d;
  logic                armed_q, armed_d;
  logic                fetch_load_q, fetch_load_d;
  logic                cap_load_q, cap_load_d;
  logic                cap_pf_q, cap_pf_d;
  logic                miso_q, miso_d;
  logic                miso_oe_q, miso_oe_d;
  logic                mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

  logic sck_rise_c, sck_fall_c;
  logic [DATA_W-1:0] id_next_c;

  // Input synchronizers; vld flags mark when the csb copy reflects the pin.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_s3_q  <= 1'b0;
      csb_s1_q  <= 1'b1;
      csb_s2_q  <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      vld1_q    <= 1'b0;
      vld2_q    <= 1'b0;
    end else begin
      sck_s1_q  <= bus.spi_clk;
      sck_s2_q  <= sck_s1_q;
      sck_s3_q  <= sck_s2_q;
      csb_s1_q  <= bus.csb;
      csb_s2_q  <= csb_s1_q;
      mosi_s1_q <= bus.mosi;
      mosi_s2_q <= mosi_s1_q;
      vld1_q    <= 1'b1;
      vld2_q    <= vld1_q;
    end
  end

  assign sck_rise_c = sck_s2_q & ~sck_s3_q;
  assign sck_fall_c = ~sck_s2_q & sck_s3_q;

  always_comb begin
    unique case (id_idx_q)
      IDX_W'(1): id_next_c = JEDEC_ID[15:8];
      IDX_W'(2): id_next_c = JEDEC_ID[7:0];
      default:   id_next_c = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    in_shift_d   = in_shift_q;
    out_shift_d  = out_shift_q;
    pf_d         = pf_q;
    addr_cnt_d   = addr_cnt_q;
    id_idx_d     = id_idx_q;
    armed_d      = armed_q | (vld2_q & csb_s2_q);
    fetch_load_d = fetch_load_q;
    cap_load_d   = mem_rd_q & fetch_load_q;
    cap_pf_d     = mem_rd_q & ~fetch_load_q;
    miso_d       = miso_q;
    mem_rd_d     = 1'b0;
    mem_addr_d   = mem_addr_q;

    // Read data arrives one cycle after the registered strobe.
    if (cap_load_q) out_shift_d = bus.mem_rdata_i;
    if (cap_pf_q)   pf_d        = bus.mem_rdata_i;

    if (csb_s2_q) begin
      state_d     = S_IDLE;
      bit_cnt_d   = '0;
      in_shift_d  = '0;
      out_shift_d = '0;
      pf_d        = '0;
      addr_cnt_d  = '0;
      id_idx_d    = '0;
      cap_load_d  = 1'b0;
      cap_pf_d    = 1'b0;
      miso_d      = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Not armed after reset until csb has been seen high.
          if (armed_q) begin
            state_d   = S_CMD;
            bit_cnt_d = '0;
          end
        end
        S_CMD: begin
          if (sck_rise_c) begin
            in_shift_d = {in_shift_q[ADDR_W-2:0], mosi_s2_q};
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(7)) begin
              bit_cnt_d = '0;
              if (in_shift_d[DATA_W-1:0] == 8'h03) begin
                state_d = S_ADDR;
              end else if (in_shift_d[DATA_W-1:0] == 8'h9F) begin
                state_d     = S_ID;
                out_shift_d = JEDEC_ID[23:16];
                id_idx_d    = IDX_W'(1);
              end else begin
                state_d = S_IGNORE;
              end
            end
          end
        end
        S_ADDR: begin
          if (sck_rise_c) begin
            in_shift_d = {in_shift_q[ADDR_W-2:0], mosi_s2_q};
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(23)) begin
              bit_cnt_d    = '0;
              mem_rd_d     = 1'b1;
              mem_addr_d   = in_shift_d;
              fetch_load_d = 1'b1;
              addr_cnt_d   = in_shift_d + ADDR_W'(1);
              state_d      = S_DATA;
            end
          end
        end
        S_DATA, S_ID: begin
          if (sck_fall_c) begin
            miso_d      = out_shift_q[DATA_W-1];
            out_shift_d = {out_shift_q[DATA_W-2:0], 1'b0};
            bit_cnt_d   = bit_cnt_q + CNT_W'(1);
            // Prefetch the next byte while this byte's MSB goes out.
            if (state_q == S_DATA && bit_cnt_q == '0) begin
              mem_rd_d     = 1'b1;
              mem_addr_d   = addr_cnt_q;
              fetch_load_d = 1'b0;
              addr_cnt_d   = addr_cnt_q + ADDR_W'(1);
            end
            if (bit_cnt_q == CNT_W'(7)) begin
              bit_cnt_d = '0;
              if (state_q == S_DATA) begin
                out_shift_d = pf_q;
              end else begin
                out_shift_d = id_next_c;
                if (id_idx_q != IDX_W'(3)) id_idx_d = id_idx_q + IDX_W'(1);
              end
            end
          end
        end
        S_IGNORE: miso_d = 1'b0;
        default:  state_d = S_IDLE;
      endcase
    end

    miso_oe_d = (state_d == S_DATA) || (state_d == S_ID);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      in_shift_q   <= '0;
      out_shift_q  <= '0;
      pf_q         <= '0;
      addr_cnt_q   <= '0;
      id_idx_q     <= '0;
      armed_q      <= 1'b0;
      fetch_load_q <= 1'b0;
      cap_load_q   <= 1'b0;
      cap_pf_q     <= 1'b0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      in_shift_q   <= in_shift_d;
      out_shift_q  <= out_shift_d;
      pf_q         <= pf_d;
      addr_cnt_q   <= addr_cnt_d;
      id_idx_q     <= id_idx_d;
      armed_q      <= armed_d;
      fetch_load_q <= fetch_load_d;
      cap_load_q   <= cap_load_d;
      cap_pf_q     <= cap_pf_d;
      miso_q       <= miso_d;
      miso_oe_q    <= miso_oe_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign bus.miso       = miso_q;
  assign bus.miso_oe    = miso_oe_q;
  assign bus.mem_rd_o   = mem_rd_q;
  assign bus.mem_addr_o = mem_addr_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: acts as SPI initiator and as the
// synchronous memory, checking returned bytes and read strobes.
module tb_spi_flash_responder;
  localparam int unsigned HALF = 60;

  logic clk;
  logic rst_i;
  int   checks;
  int   errors;
  int   consec;
  logic prev_rd;
  logic [23:0] strobes[$];

  spi_flash_responder_if bus_if();

  spi_flash_responder dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_val(input logic [23:0] a);
    case (a)
      24'h000010: return 8'hA5;
      24'h000011: return 8'h3C;
      24'hFFFFFF: return 8'h81;
      24'h000000: return 8'h7E;
      default:    return a[7:0] ^ 8'hC3;
    endcase
  endfunction

  // Memory: data valid only in the cycle after the strobe.
  initial prev_rd = 1'b0;
  always @(posedge clk) begin
    if (bus_if.mem_rd_o) begin
      bus_if.mem_rdata_i <= mem_val(bus_if.mem_addr_o);
      strobes.push_back(bus_if.mem_addr_o);
    end else begin
      bus_if.mem_rdata_i <= 8'hEE;
    end
    if (bus_if.mem_rd_o && prev_rd) consec++;
    prev_rd <= bus_if.mem_rd_o;
  end

  task automatic spi_bit(input logic tx, input logic last, output logic rx, output logic oe);
    bus_if.mosi = tx;
    #HALF;
    bus_if.spi_clk = 1'b1;
    rx = bus_if.miso;
    oe = bus_if.miso_oe;
    #HALF;
    bus_if.spi_clk = 1'b0;
    if (last) bus_if.csb = 1'b1;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input logic last, output logic [7:0] rx,
                          output logic oe_and, output logic oe_or);
    logic r, o;
    rx = '0; oe_and = 1'b1; oe_or = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], last && (i == 0), r, o);
      rx = {rx[6:0], r};
      oe_and &= o;
      oe_or  |= o;
    end
  endtask

  task automatic spi_txn(input logic [7:0] cmd, input logic send_addr, input logic [23:0] addr,
                         input int nbytes, output logic [31:0] rx,
                         output logic oe_and, output logic oe_or);
    logic [7:0] r;
    logic a, o;
    rx = '0; oe_and = 1'b1; oe_or = 1'b0;
    bus_if.csb = 1'b0;
    spi_byte(cmd, !send_addr && nbytes == 0, r, a, o);
    if (send_addr)
      for (int i = 2; i >= 0; i--) spi_byte(addr[8*i +: 8], i == 0 && nbytes == 0, r, a, o);
    for (int b = 0; b < nbytes; b++) begin
      spi_byte(8'h00, b == nbytes - 1, r, a, o);
      rx = {rx[23:0], r};
      oe_and &= a;
      oe_or  |= o;
    end
    #(HALF * 2);
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      bus_if.spi_clk = 1'($urandom);
      bus_if.csb     = 1'($urandom);
      bus_if.mosi    = 1'($urandom);
    end
    @(negedge clk);
    checks++; if (bus_if.miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", bus_if.miso); end
    checks++; if (bus_if.miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", bus_if.miso_oe); end
    checks++; if (bus_if.mem_rd_o !== 1'b0) begin errors++; $display("FAIL reset_rd got %b exp 0", bus_if.mem_rd_o); end
    checks++; if (bus_if.mem_addr_o !== 24'h0) begin errors++; $display("FAIL reset_addr got %h exp 000000", bus_if.mem_addr_o); end
    bus_if.spi_clk = 1'b0; bus_if.csb = 1'b1; bus_if.mosi = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    repeat (5) @(posedge clk);
    #2;
  endtask

  task automatic test_read;
    logic [31:0] rx;
    logic a, o;
    logic [23:0] exp_a [3];
    exp_a = '{24'h000010, 24'h000011, 24'h000012};
    strobes.delete(); consec = 0;
    spi_txn(8'h03, 1'b1, 24'h000010, 2, rx, a, o);
    checks++; if (rx[15:8] !== 8'hA5) begin errors++; $display("FAIL read_byte0 got %h exp a5", rx[15:8]); end
    checks++; if (rx[7:0] !== 8'h3C) begin errors++; $display("FAIL read_byte1 got %h exp 3c", rx[7:0]); end
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL read_oe got %b exp 1", a); end
    checks++;
    if (strobes.size() != 3) begin
      errors++; $display("FAIL read_strobe_count got %0d exp 3", strobes.size());
    end else begin
      for (int i = 0; i < 3; i++)
        if (strobes[i] !== exp_a[i]) begin errors++; $display("FAIL read_strobe_addr%0d got %h exp %h", i, strobes[i], exp_a[i]); end
    end
    checks++; if (consec !== 0) begin errors++; $display("FAIL read_consec_strobes got %0d exp 0", consec); end
    checks++; if (bus_if.miso_oe !== 1'b0) begin errors++; $display("FAIL read_oe_after got %b exp 0", bus_if.miso_oe); end
  endtask

  task automatic test_wrap;
    logic [31:0] rx;
    logic a, o;
    strobes.delete();
    spi_txn(8'h03, 1'b1, 24'hFFFFFF, 2, rx, a, o);
    checks++; if (rx[15:0] !== 16'h817E) begin errors++; $display("FAIL wrap_data got %h exp 817e", rx[15:0]); end
    checks++;
    if (strobes.size() != 3) begin
      errors++; $display("FAIL wrap_strobe_count got %0d exp 3", strobes.size());
    end else begin
      if (strobes[0] !== 24'hFFFFFF) begin errors++; $display("FAIL wrap_addr0 got %h exp ffffff", strobes[0]); end
      if (strobes[1] !== 24'h000000) begin errors++; $display("FAIL wrap_addr1 got %h exp 000000", strobes[1]); end
    end
  endtask

  task automatic test_jedec;
    logic [31:0] rx;
    logic a, o;
    strobes.delete();
    spi_txn(8'h9F, 1'b0, 24'h0, 4, rx, a, o);
    checks++; if (rx !== 32'hEF401600) begin errors++; $display("FAIL jedec_data got %h exp ef401600", rx); end
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL jedec_oe got %b exp 1", a); end
    checks++; if (strobes.size() != 0) begin errors++; $display("FAIL jedec_strobes got %0d exp 0", strobes.size()); end
  endtask

  task automatic test_ignore_abort;
    logic [31:0] rx;
    logic [7:0] r;
    logic a, o;
    strobes.delete();
    spi_txn(8'hFF, 1'b0, 24'h0, 1, rx, a, o);
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL ignore_oe got %b exp 0", o); end
    checks++; if (rx[7:0] !== 8'h00) begin errors++; $display("FAIL ignore_miso got %h exp 00", rx[7:0]); end
    bus_if.csb = 1'b0;
    spi_byte(8'h03, 1'b0, r, a, o);
    spi_byte(8'h12, 1'b1, r, a, o);
    #(HALF * 2);
    checks++; if (strobes.size() != 0) begin errors++; $display("FAIL abort_strobes got %0d exp 0", strobes.size()); end
    spi_txn(8'h03, 1'b1, 24'h000010, 1, rx, a, o);
    checks++; if (rx[7:0] !== 8'hA5) begin errors++; $display("FAIL abort_read got %h exp a5", rx[7:0]); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] r;
    logic [3:0] nib;
    logic [31:0] rx;
    logic a, o, rb, ob, oe_or;
    bus_if.csb = 1'b0;
    spi_byte(8'h03, 1'b0, r, a, o);
    spi_byte(8'h00, 1'b0, r, a, o);
    spi_byte(8'h00, 1'b0, r, a, o);
    spi_byte(8'h10, 1'b0, r, a, o);
    nib = '0;
    for (int i = 0; i < 4; i++) begin
      spi_bit(1'b0, 1'b0, rb, ob);
      nib = {nib[2:0], rb};
    end
    checks++; if (nib !== 4'hA) begin errors++; $display("FAIL mid_nibble got %h exp a", nib); end
    @(posedge clk); #2;
    rst_i = 1'b1;
    @(posedge clk); #2;
    rst_i = 1'b0;
    checks++; if (bus_if.miso !== 1'b0) begin errors++; $display("FAIL mid_rst_miso got %b exp 0", bus_if.miso); end
    checks++; if (bus_if.miso_oe !== 1'b0) begin errors++; $display("FAIL mid_rst_oe got %b exp 0", bus_if.miso_oe); end
    checks++; if (bus_if.mem_rd_o !== 1'b0) begin errors++; $display("FAIL mid_rst_rd got %b exp 0", bus_if.mem_rd_o); end
    checks++; if (bus_if.mem_addr_o !== 24'h0) begin errors++; $display("FAIL mid_rst_addr got %h exp 000000", bus_if.mem_addr_o); end
    strobes.delete();
    oe_or = 1'b0;
    for (int i = 0; i < 4; i++) begin
      spi_bit(1'b0, i == 3, rb, ob);
      oe_or |= ob;
    end
    #(HALF * 2);
    checks++; if (oe_or !== 1'b0 || strobes.size() != 0) begin
      errors++; $display("FAIL mid_after_rst got oe %b strobes %0d exp 0 0", oe_or, strobes.size());
    end
    spi_txn(8'h03, 1'b1, 24'h000010, 2, rx, a, o);
    checks++; if (rx[15:0] !== 16'hA53C) begin errors++; $display("FAIL mid_reread got %h exp a53c", rx[15:0]); end
  endtask

  initial begin
    checks = 0; errors = 0; consec = 0;
    rst_i = 1'b1;
    bus_if.spi_clk = 1'b0;
    bus_if.csb = 1'b1;
    bus_if.mosi = 1'b0;
    test_reset();
    test_read();
    test_wrap();
    test_jedec();
    test_ignore_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

Synthesizable SPI mode-0 flash responder that answers the serial read traffic produced by the team's SPI flash reader, so the reader can be exercised in simulation and on FPGA without a physical flash part. It oversamples `spi_clk`, `csb` and `mosi` in the `clk_i` domain, decodes READ (0x03) and JEDEC-ID (0x9F) commands, fetches bytes from an external synchronous memory port and shifts them out on `miso`, MSB first.

## Interface
- `JEDEC_ID`, 24'hEF4016, ID bytes returned for 0x9F, MSB byte first
- `clk_i`  in  1  system clock; must run ≥ 8× `spi_clk`
- `rst_i`  in  1  reset, synchronous, active-high
- `spi_clk`  in  1  serial clock from initiator, idle low
- `csb`  in  1  chip select, active low
- `mosi`  in  1  serial data from initiator
- `miso`  out  1  serial data to initiator
- `miso_oe`  out  1  high while a data phase is driving `miso`
- `mem_rd_o`  out  1  one-cycle read strobe
- `mem_addr_o`  out  24  byte address of the read
- `mem_rdata_i`  in  8  read data, valid exactly 1 `clk_i` after `mem_rd_o`

## Operation
- `spi_clk`, `csb`, `mosi` pass through 2-flop synchronizers; rising/falling SCK edges detected from synchronized copy (one-cycle pulses).
- States: IDLE, CMD, ADDR, DATA, ID, IGNORE.
- IDLE: waiting for `csb` low → CMD, bit counter = 0.
- CMD: shift `mosi` on each SCK rise, MSB first; after 8th bit: 0x03 → ADDR, 0x9F → ID, any other value (incl. 0xFF, 0xAB) → IGNORE.
- ADDR: shift 24 bits on SCK rises. On 24th rise: `mem_rd_o`=1, `mem_addr_o`=address; next cycle latch `mem_rdata_i` into shift register; → DATA, address counter = address+1.
- DATA: on each SCK fall, drive `miso` = current shift-register MSB, then shift left. After 8th bit has been driven, load the prefetched byte. Prefetch: when a byte's MSB is driven, pulse `mem_rd_o` for address counter, latch result into prefetch register, increment counter. Address wraps 0xFFFFFF → 0x000000.
- ID: same shift mechanism, bytes `JEDEC_ID[23:16]`, `[15:8]`, `[7:0]`, then 0x00 repeated; no memory reads.
- IGNORE: `miso`=0, `miso_oe`=0, no memory activity until `csb` high.
- Synchronized `csb` high in any state → IDLE next cycle; counters, shift registers cleared; `miso`=0, `miso_oe`=0. Pending prefetch data discarded.
- `miso_oe`=1 only in DATA and ID states.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `mem_rd_o`=0, `mem_addr_o`=0, state IDLE, synchronizer flops 0 (`csb` sync reset to 1).
- SCK edge → internal action: 3 `clk_i` (2 sync + 1 edge register).
- First data bit: driven on the SCK fall following the 24th address rise; memory data (1 cycle after strobe) ready ≥ 2 `clk_i` before that fall given the ≥8× ratio.
- Bit N of any data byte is stable from the SCK fall before rise N until the next SCK fall (mode 0).
- `mem_rd_o` never asserted on two consecutive cycles; exactly one strobe per output byte in DATA.
- Reset has priority over all edges; `rst_i` mid-transfer returns to IDLE in one cycle; a transfer continuing on the bus after reset is ignored until `csb` toggles high then low.
- SCK edges with `csb` high are ignored.

## Test plan
- Reset: assert `rst_i` 3 cycles with random bus activity → `miso`=0, `miso_oe`=0, `mem_rd_o`=0, `mem_addr_o`=0.
- READ: mem[0x000010]=0xA5, mem[0x000011]=0x3C; send 0x03 0x00 0x00 0x10, clock 16 bits → `miso` bytes 0xA5, 0x3C; strobes at addresses 0x10, 0x11, 0x12.
- Wrap: mem[0xFFFFFF]=0x81, mem[0x000000]=0x7E; READ at 0xFFFFFF for 2 bytes → 0x81, 0x7E; `mem_addr_o` goes 0xFFFFFF, 0x000000.
- JEDEC: send 0x9F, clock 32 bits → 0xEF, 0x40, 0x16, 0x00; `mem_rd_o` never asserted.
- Ignore/abort: send 0xFF then 8 clocks → `miso_oe`=0 throughout; send 0x03 0x12, raise `csb` mid-address, then full READ at 0x000010 → 0xA5 returned correctly.
- Reset mid-DATA: assert `rst_i` after 4 data bits of a READ → outputs to reset values next cycle; following full READ transaction returns correct data.
